corner_adjust: RTL and testbench
================================

# corner_adjust

Parametrised manual-correction block for the projector quadrilateral: passes NUM_PTS raw corner coordinates through to the warp logic, or, while `override` is high, freezes them and lets the user nudge the selected corner with the arrow keys. The block adds edge-triggered stepping, hold-to-repeat with a speed-up, and clamp-to-screen arithmetic. It sits between the accelerometer LUT outputs and the perspective-transform stage.

## Interface
- NUM_PTS, 4: number of corners; 2..16.
- XW, 10: x coordinate width.
- YW, 9: y coordinate width.
- SCR_WIDTH, 639: maximum legal x.
- SCR_HEIGHT, 479: maximum legal y.
- XSPEED, 1: base x step.
- YSPEED, 1: base y step.
- REPEAT_DELAY, 2_500_000: cycles a key is held before auto-repeat starts; ≥2.
- REPEAT_PERIOD, 500_000: cycles between repeat steps; ≥1.
- FAST_AFTER, 8: repeat steps before fast mode.
- FAST_MULT, 4: step multiplier in fast mode.
- SW, $clog2(NUM_PTS): select width.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high.
- up, down, left, right  in  1 each  level key inputs, already debounced and synchronised.
- override  in  1  manual mode enable.
- sel  in  SW  corner index being edited.
- xs_raw  in  NUM_PTS*XW  packed raw x; corner i at [i*XW +: XW].
- ys_raw  in  NUM_PTS*YW  packed raw y; same packing.
- xs  out  NUM_PTS*XW  registered corrected x.
- ys  out  NUM_PTS*YW  registered corrected y.
- editing  out  1  high in every state except PASS.
- fast  out  1  high while fast-mode stepping is active.

## Operation
- Effective direction: fixed priority down > up > left > right; NONE if no key is pressed.
- FSM states: PASS, IDLE, DELAY, REPEAT.
  - PASS: xs/ys <= raw every cycle. When `override` goes high: capture raw → IDLE. No step on the capture cycle.
  - IDLE: when dir ≠ NONE: one step → DELAY, counter cleared.
  - DELAY: dir = NONE → IDLE. Counter reaches REPEAT_DELAY-1 → step → REPEAT.
  - REPEAT: step every REPEAT_PERIOD cycles. Repeat count saturates at FAST_AFTER. `fast` = (count == FAST_AFTER). dir = NONE → IDLE.
- From IDLE/DELAY/REPEAT, `override` low → PASS, with outputs following raw from the same edge.
- Change of effective dir or `sel` while in DELAY/REPEAT counts as a new press:
  - immediate step → DELAY;
  - counters and `fast` cleared.
- `sel` ≥ NUM_PTS: no steps, and the FSM stays in or returns to IDLE.
- Step size:
  - x uses XSPEED, or XSPEED*FAST_MULT when `fast`;
  - y uses YSPEED, or YSPEED*FAST_MULT when `fast`.
- Arithmetic is done one bit wider, with clamping:
  - increment: min(v+step, MAX);
  - decrement: (v ≥ step) ? v−step : 0.
  - A coordinate at its bound stays there; it never wraps.
- Only the selected corner's coordinate changes. All other corners hold.

## Timing
- Reset: all xs/ys = 0, state PASS, counters 0, editing = 0, fast = 0.
- Outputs are registered. In PASS, raw-to-output latency is 1 cycle.
- Key press in IDLE: coordinate updates on the first clk edge that samples the key.
- Held key: 2nd step REPEAT_DELAY cycles after the 1st; then one step every REPEAT_PERIOD cycles.
- `fast` asserts on the cycle after the FAST_AFTER-th repeat step; the next step uses the fast size.
- `editing` changes in the same cycle as the state register.
- Reset asserted mid-hold: immediate return to reset values. After release, the block re-enters via PASS and re-captures raw.

## Structure
- Shared package `corner_adjust_pkg`: dir_t enum {NONE, UP, DOWN, LEFT, RIGHT}, state_t enum, and the packing helper index macros.
- Sub-module `key_repeat`:
  - inputs: clk, reset, enable, dir code, sel;
  - outputs: step pulse, fast;
  - holds the FSM and both counters.
- Top level keeps the coordinate registers and the clamp adders.

## Test plan
Bench parameters: NUM_PTS=4, REPEAT_DELAY=8, REPEAT_PERIOD=4, FAST_AFTER=3, FAST_MULT=4.

- Pass-through: raw x2=100, y2=50, override=0 → xs[2]=100, ys[2]=50 one cycle later. Change raw x2 → output follows.
- Capture and tap: override=1, sel=1, raw x1=200. Change raw x1 to 300 → output stays 200. Pulse right 1 cycle → x1=201, exactly one step.
- Repeat and fast: sel=0, y0=10, hold down 40 cycles.
  - Steps at cycles 0, 8, 12, 16, 20 (fast asserts after the step at 20).
  - Fast steps of 4 at cycles 24, 28, 32, 36.
  - Final y0 = 15+16 = 31.
- Clamp: x3=637, hold right in fast mode → x3 = 639, never wraps. y0=2, press up in fast mode → 0.
- Re-press on change: hold left, switch sel 0→2 mid-REPEAT → corner 2 steps immediately, fast=0, next step 8 cycles later.
- Exit/reset: deassert override mid-REPEAT → outputs = raw next cycle, editing=0. Assert reset while held → all outputs 0 asynchronously.

Source files
------------

// File: rtl/corner_adjust_pkg.sv
// corner_adjust_pkg
// Shared types and helpers for the projector corner-correction block.
//   dir_t      : effective arrow-key direction after priority resolution
//   state_t    : key-repeat FSM state
//   lo_idx     : low bit index of element i in a packed array of w-bit fields
//   dir_encode : fixed-priority key resolution (down > up > left > right)
package corner_adjust_pkg;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    UP    = 3'd1,
    DOWN  = 3'd2,
    LEFT  = 3'd3,
    RIGHT = 3'd4
  } dir_t;

  typedef enum logic [1:0] {
    PASS   = 2'd0,
    IDLE   = 2'd1,
    DELAY  = 2'd2,
    REPEAT = 2'd3
  } state_t;

  // Corner i of a packed coordinate bus occupies [lo_idx(i, w) +: w].
  function automatic int lo_idx(input int i, input int w);
    return i * w;
  endfunction

  function automatic dir_t dir_encode(input logic k_up, input logic k_down,
                                      input logic k_left, input logic k_right);
    dir_t d;
    if (k_down) begin
      d = DOWN;
    end else if (k_up) begin
      d = UP;
    end else if (k_left) begin
      d = LEFT;
    end else if (k_right) begin
      d = RIGHT;
    end else begin
      d = NONE;
    end
    return d;
  endfunction

endpackage

// File: rtl/corner_adjust_key_repeat.sv
// key_repeat
// Key-repeat FSM for manual corner nudging. Produces one step pulse per key
// press, then auto-repeat steps after REPEAT_DELAY cycles, every
// REPEAT_PERIOD cycles, switching to fast steps after FAST_AFTER repeats.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   enable      : manual mode (override) request
//   dir         : effective direction code (dir_t)
//   sel         : selected corner index
//   step        : combinational pulse, apply one step on this edge
//   step_fast   : the current step uses the fast step size
//   fast        : registered, fast-mode stepping active
//   editing     : registered, high in every state except PASS
module key_repeat
  import corner_adjust_pkg::*;
#(
  parameter int NUM_PTS       = 4,
  parameter int REPEAT_DELAY  = 2_500_000,
  parameter int REPEAT_PERIOD = 500_000,
  parameter int FAST_AFTER    = 8,
  parameter int SW            = $clog2(NUM_PTS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [2:0]    dir,
  input  logic [SW-1:0] sel,
  output logic          step,
  output logic          step_fast,
  output logic          fast,
  output logic          editing
);

  localparam int DCW = $clog2(REPEAT_DELAY + 1);
  localparam int PCW = $clog2(REPEAT_PERIOD + 1);
  localparam int RCW = (FAST_AFTER > 0) ? $clog2(FAST_AFTER + 1) : 1;
  localparam logic [DCW-1:0] DLY_LAST = DCW'(REPEAT_DELAY - 1);
  localparam logic [PCW-1:0] PER_LAST = PCW'(REPEAT_PERIOD - 1);
  localparam logic [RCW-1:0] REP_SAT  = RCW'(FAST_AFTER);

  state_t         state_r, state_next_s;
  dir_t           dir_s, dir_r;
  logic [SW-1:0]  sel_r;
  logic [DCW-1:0] dly_cnt_r;
  logic [PCW-1:0] per_cnt_r;
  logic [RCW-1:0] rep_cnt_r, rep_next_s;
  logic           fast_r, fast_next_s, editing_r;
  logic           active_s, changed_s, dly_last_s, per_last_s;
  logic           step_s, press_s, rep_step_s;

  assign dir_s      = dir_t'(dir);
  // A step needs manual mode, a pressed key and an existing corner.
  assign active_s   = enable && (dir_s != NONE) && (int'(sel) < NUM_PTS);
  // Different key or corner than the one latched at the last press.
  assign changed_s  = (dir_s != dir_r) || (sel != sel_r);
  assign dly_last_s = (dly_cnt_r == DLY_LAST);
  assign per_last_s = (per_cnt_r == PER_LAST);

  // State register, with editing tracking the state register exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= PASS;
      editing_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      editing_r <= (state_next_s != PASS);
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      PASS: begin
        if (enable) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = PASS;
        end
      end
      IDLE: begin
        if (!enable) begin
          state_next_s = PASS;
        end else if (active_s) begin
          state_next_s = DELAY;
        end else begin
          state_next_s = IDLE;
        end
      end
      DELAY: begin
        if (!enable) begin
          state_next_s = PASS;
        end else if (!active_s) begin
          state_next_s = IDLE;
        end else if (changed_s) begin
          state_next_s = DELAY;
        end else if (dly_last_s) begin
          state_next_s = REPEAT;
        end else begin
          state_next_s = DELAY;
        end
      end
      REPEAT: begin
        if (!enable) begin
          state_next_s = PASS;
        end else if (!active_s) begin
          state_next_s = IDLE;
        end else if (changed_s) begin
          state_next_s = DELAY;
        end else begin
          state_next_s = REPEAT;
        end
      end
      default: state_next_s = PASS;
    endcase
  end

  // Output logic: step pulses and counter control.
  always_comb begin
    step_s     = 1'b0;
    press_s    = 1'b0;
    rep_step_s = 1'b0;
    case (state_r)
      PASS: begin
        step_s = 1'b0;
      end
      IDLE: begin
        step_s  = active_s;
        press_s = active_s;
      end
      DELAY: begin
        if (active_s && changed_s) begin
          step_s  = 1'b1;
          press_s = 1'b1;
        end else if (active_s && dly_last_s) begin
          step_s = 1'b1;
        end else begin
          step_s = 1'b0;
        end
      end
      REPEAT: begin
        if (active_s && changed_s) begin
          step_s  = 1'b1;
          press_s = 1'b1;
        end else if (active_s && per_last_s) begin
          step_s     = 1'b1;
          rep_step_s = 1'b1;
        end else begin
          step_s = 1'b0;
        end
      end
      default: step_s = 1'b0;
    endcase

    // Repeat count lives only inside REPEAT and saturates at FAST_AFTER.
    if (state_next_s != REPEAT) begin
      rep_next_s = {RCW{1'b0}};
    end else if (rep_step_s && (rep_cnt_r != REP_SAT)) begin
      rep_next_s = rep_cnt_r + 1'b1;
    end else begin
      rep_next_s = rep_cnt_r;
    end
    fast_next_s = (state_next_s == REPEAT) && (rep_next_s == REP_SAT);
  end

  // Delay/period/repeat counters and the latched press identity.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dly_cnt_r <= {DCW{1'b0}};
      per_cnt_r <= {PCW{1'b0}};
      rep_cnt_r <= {RCW{1'b0}};
      fast_r    <= 1'b0;
      dir_r     <= NONE;
      sel_r     <= {SW{1'b0}};
    end else begin
      if ((state_r != DELAY) || press_s) begin
        dly_cnt_r <= {DCW{1'b0}};
      end else begin
        dly_cnt_r <= dly_cnt_r + 1'b1;
      end
      if ((state_r != REPEAT) || per_last_s) begin
        per_cnt_r <= {PCW{1'b0}};
      end else begin
        per_cnt_r <= per_cnt_r + 1'b1;
      end
      rep_cnt_r <= rep_next_s;
      fast_r    <= fast_next_s;
      if (press_s) begin
        dir_r <= dir_s;
        sel_r <= sel;
      end else begin
        dir_r <= dir_r;
        sel_r <= sel_r;
      end
    end
  end

  // A fresh press always uses the base step, even coming out of fast mode.
  assign step      = step_s;
  assign step_fast = step_s && fast_r && !press_s;
  assign fast      = fast_r;
  assign editing   = editing_r;

endmodule

// File: rtl/corner_adjust.sv
// corner_adjust
// Manual correction of the projector quadrilateral corners. Passes raw
// corners through (1-cycle registered) or, while override is high, freezes
// them and nudges the selected corner with the arrow keys, clamped to the
// screen.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   up, down, left, right : debounced key levels
//   override              : manual mode enable
//   sel                   : corner being edited
//   xs_raw, ys_raw        : packed raw corners, corner i at [i*W +: W]
//   xs, ys                : registered corrected corners, same packing
//   editing               : high in every state except PASS
//   fast                  : fast-mode stepping active
module corner_adjust
  import corner_adjust_pkg::*;
#(
  parameter int NUM_PTS       = 4,
  parameter int XW            = 10,
  parameter int YW            = 9,
  parameter int SCR_WIDTH     = 639,
  parameter int SCR_HEIGHT    = 479,
  parameter int XSPEED        = 1,
  parameter int YSPEED        = 1,
  parameter int REPEAT_DELAY  = 2_500_000,
  parameter int REPEAT_PERIOD = 500_000,
  parameter int FAST_AFTER    = 8,
  parameter int FAST_MULT     = 4,
  parameter int SW            = $clog2(NUM_PTS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  up,
  input  logic                  down,
  input  logic                  left,
  input  logic                  right,
  input  logic                  override,
  input  logic [SW-1:0]         sel,
  input  logic [NUM_PTS*XW-1:0] xs_raw,
  input  logic [NUM_PTS*YW-1:0] ys_raw,
  output logic [NUM_PTS*XW-1:0] xs,
  output logic [NUM_PTS*YW-1:0] ys,
  output logic                  editing,
  output logic                  fast
);

  localparam logic [XW:0] X_MAX       = (XW+1)'(SCR_WIDTH);
  localparam logic [YW:0] Y_MAX       = (YW+1)'(SCR_HEIGHT);
  localparam logic [XW:0] X_STEP      = (XW+1)'(XSPEED);
  localparam logic [YW:0] Y_STEP      = (YW+1)'(YSPEED);
  localparam logic [XW:0] X_STEP_FAST = (XW+1)'(XSPEED * FAST_MULT);
  localparam logic [YW:0] Y_STEP_FAST = (YW+1)'(YSPEED * FAST_MULT);

  dir_t                  dir_s;
  logic                  step_s, step_fast_s, fast_s, editing_s, load_raw_s;
  logic [XW-1:0]         x_sel_s, x_new_s;
  logic [YW-1:0]         y_sel_s, y_new_s;
  logic [XW:0]           x_cur_w, x_step_w, x_sum_w;
  logic [YW:0]           y_cur_w, y_step_w, y_sum_w;
  logic [NUM_PTS*XW-1:0] xs_r, xs_next_s;
  logic [NUM_PTS*YW-1:0] ys_r, ys_next_s;

  assign dir_s = dir_encode(up, down, left, right);

  key_repeat #(
    .NUM_PTS       (NUM_PTS),
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD),
    .FAST_AFTER    (FAST_AFTER),
    .SW            (SW)
  ) u_key_repeat (
    .clk       (clk),
    .reset     (reset),
    .enable    (override),
    .dir       (dir_s),
    .sel       (sel),
    .step      (step_s),
    .step_fast (step_fast_s),
    .fast      (fast_s),
    .editing   (editing_s)
  );

  // Raw is loaded in PASS (which includes the capture edge) and on the
  // edge where override drops, so outputs follow raw from that edge.
  assign load_raw_s = !override || !editing_s;

  // Select the edited corner and compute its clamped neighbour values.
  always_comb begin
    x_sel_s = {XW{1'b0}};
    y_sel_s = {YW{1'b0}};
    for (int i = 0; i < NUM_PTS; i++) begin
      if (int'(sel) == i) begin
        x_sel_s = xs_r[lo_idx(i, XW) +: XW];
        y_sel_s = ys_r[lo_idx(i, YW) +: YW];
      end else begin
        x_sel_s = x_sel_s;
        y_sel_s = y_sel_s;
      end
    end

    // One bit of headroom so the sum can exceed the bound before clamping.
    x_cur_w  = {1'b0, x_sel_s};
    y_cur_w  = {1'b0, y_sel_s};
    x_step_w = step_fast_s ? X_STEP_FAST : X_STEP;
    y_step_w = step_fast_s ? Y_STEP_FAST : Y_STEP;
    x_sum_w  = x_cur_w + x_step_w;
    y_sum_w  = y_cur_w + y_step_w;

    case (dir_s)
      RIGHT:   x_new_s = (x_sum_w > X_MAX) ? X_MAX[XW-1:0] : x_sum_w[XW-1:0];
      LEFT:    x_new_s = (x_cur_w >= x_step_w) ? XW'(x_cur_w - x_step_w) : {XW{1'b0}};
      default: x_new_s = x_sel_s;
    endcase

    // Screen y grows downwards: down increments, up decrements.
    case (dir_s)
      DOWN:    y_new_s = (y_sum_w > Y_MAX) ? Y_MAX[YW-1:0] : y_sum_w[YW-1:0];
      UP:      y_new_s = (y_cur_w >= y_step_w) ? YW'(y_cur_w - y_step_w) : {YW{1'b0}};
      default: y_new_s = y_sel_s;
    endcase
  end

  // Write the stepped value back into the selected corner only.
  always_comb begin
    xs_next_s = xs_r;
    ys_next_s = ys_r;
    for (int i = 0; i < NUM_PTS; i++) begin
      if (step_s && (int'(sel) == i)) begin
        xs_next_s[lo_idx(i, XW) +: XW] = x_new_s;
        ys_next_s[lo_idx(i, YW) +: YW] = y_new_s;
      end else begin
        xs_next_s = xs_next_s;
        ys_next_s = ys_next_s;
      end
    end
  end

  // Coordinate registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xs_r <= {(NUM_PTS*XW){1'b0}};
      ys_r <= {(NUM_PTS*YW){1'b0}};
    end else if (load_raw_s) begin
      xs_r <= xs_raw;
      ys_r <= ys_raw;
    end else begin
      xs_r <= xs_next_s;
      ys_r <= ys_next_s;
    end
  end

  assign xs      = xs_r;
  assign ys      = ys_r;
  assign editing = editing_s;
  assign fast    = fast_s;

endmodule

// File: tb/tb_corner_adjust.sv
// tb_corner_adjust
// Self-checking bench for corner_adjust with short repeat timings.
module tb_corner_adjust;

  localparam int NP = 4;
  localparam int XW = 10;
  localparam int YW = 9;
  localparam int SW = 2;

  localparam int K_X    = 0;
  localparam int K_Y    = 1;
  localparam int K_EDIT = 2;
  localparam int K_FAST = 3;
  localparam int K_ZERO = 4;

  logic clk = 1'b0;
  logic reset, up, down, left, right, override;
  logic [SW-1:0]    sel;
  logic [NP*XW-1:0] xs_raw, xs;
  logic [NP*YW-1:0] ys_raw, ys;
  logic editing, fast;

  always #5 clk = ~clk;

  corner_adjust #(
    .NUM_PTS       (NP),
    .XW            (XW),
    .YW            (YW),
    .SCR_WIDTH     (639),
    .SCR_HEIGHT    (479),
    .XSPEED        (1),
    .YSPEED        (1),
    .REPEAT_DELAY  (8),
    .REPEAT_PERIOD (4),
    .FAST_AFTER    (3),
    .FAST_MULT     (4),
    .SW            (SW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .up       (up),
    .down     (down),
    .left     (left),
    .right    (right),
    .override (override),
    .sel      (sel),
    .xs_raw   (xs_raw),
    .ys_raw   (ys_raw),
    .xs       (xs),
    .ys       (ys),
    .editing  (editing),
    .fast     (fast)
  );

  typedef struct {
    string name;
    int    kind;
    int    idx;
    int    val;
  } exp_t;

  typedef struct {
    int x2;
    int y2;
    int ex;
    int ey;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[4];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic int actual_of(input int kind, input int idx);
    case (kind)
      K_X:    return int'(xs[idx*XW +: XW]);
      K_Y:    return int'(ys[idx*YW +: YW]);
      K_EDIT: return int'(editing);
      K_FAST: return int'(fast);
      K_ZERO: return ((xs == '0) && (ys == '0)) ? 1 : 0;
      default: return -1;
    endcase
  endfunction

  task automatic expect_val(input string name, input int kind, input int idx, input int val);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.idx  = idx;
    e.val  = val;
    sb_q.push_back(e);
  endtask

  task automatic check_now();
    exp_t e;
    int   a;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      a = actual_of(e.kind, e.idx);
      n_total++;
      if (a == e.val) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got %0d, expected %0d", e.name, a, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check_now();
  endtask

  task automatic set_x(input int i, input int v);
    xs_raw[i*XW +: XW] = XW'(v);
  endtask

  task automatic set_y(input int i, input int v);
    ys_raw[i*YW +: YW] = YW'(v);
  endtask

  // Holds the already-pressed key for ncyc edges. Steps land on edge 0,
  // edge 8, then every 4 edges; the 3rd repeat step (edge 20) turns fast on,
  // so steps from edge 24 are 4 wide.
  task automatic run_hold(input string name, input int kind, input int idx,
                          input int start, input bit inc, input int maxv, input int ncyc);
    int e;
    int sz;
    e = start;
    for (int k = 0; k < ncyc; k++) begin
      if ((k == 0) || ((k >= 8) && (((k - 8) % 4) == 0))) begin
        sz = (k >= 24) ? 4 : 1;
        if (inc) begin
          e = ((e + sz) > maxv) ? maxv : (e + sz);
        end else begin
          e = (e >= sz) ? (e - sz) : 0;
        end
      end
      expect_val(name, kind, idx, e);
      expect_val({name, "_fast"}, K_FAST, 0, (k >= 20) ? 1 : 0);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int px;
    int py;

    vecs[0] = '{x2: 100,  y2: 50,  ex: 100,  ey: 50};
    vecs[1] = '{x2: 321,  y2: 50,  ex: 321,  ey: 50};
    vecs[2] = '{x2: 0,    y2: 0,   ex: 0,    ey: 0};
    vecs[3] = '{x2: 1023, y2: 511, ex: 1023, ey: 511};

    reset    = 1'b1;
    up       = 1'b0;
    down     = 1'b0;
    left     = 1'b0;
    right    = 1'b0;
    override = 1'b0;
    sel      = 2'd0;
    xs_raw   = {NP{10'd7}};
    ys_raw   = {NP{9'd9}};

    // Reset state
    @(negedge clk);
    expect_val("reset_zero", K_ZERO, 0, 1);
    expect_val("reset_editing", K_EDIT, 0, 0);
    expect_val("reset_fast", K_FAST, 0, 0);
    check_now();
    reset = 1'b0;

    // Pass-through table, with the 1-cycle latency checked before each edge
    px = 0;
    py = 0;
    for (int i = 0; i < 4; i++) begin
      set_x(2, vecs[i].x2);
      set_y(2, vecs[i].y2);
      expect_val("pass_latency_x2", K_X, 2, px);
      expect_val("pass_latency_y2", K_Y, 2, py);
      check_now();
      expect_val("pass_x2", K_X, 2, vecs[i].ex);
      expect_val("pass_y2", K_Y, 2, vecs[i].ey);
      expect_val("pass_editing", K_EDIT, 0, 0);
      tick();
      px = vecs[i].ex;
      py = vecs[i].ey;
    end

    // Capture and single tap
    set_x(1, 200);
    override = 1'b1;
    sel      = 2'd1;
    expect_val("capture_x1", K_X, 1, 200);
    expect_val("capture_editing", K_EDIT, 0, 1);
    tick();
    set_x(1, 300);
    expect_val("frozen_x1", K_X, 1, 200);
    tick();
    right = 1'b1;
    expect_val("tap_x1", K_X, 1, 201);
    tick();
    right = 1'b0;
    expect_val("tap_release_x1", K_X, 1, 201);
    tick();
    expect_val("tap_once_x1", K_X, 1, 201);
    expect_val("tap_editing", K_EDIT, 0, 1);
    tick();

    // Hold down on corner 0: repeat then fast
    override = 1'b0;
    set_y(0, 10);
    expect_val("reload_y0", K_Y, 0, 10);
    expect_val("reload_editing", K_EDIT, 0, 0);
    tick();
    override = 1'b1;
    sel      = 2'd0;
    tick();
    down = 1'b1;
    run_hold("hold_y0", K_Y, 0, 10, 1'b1, 479, 40);
    down = 1'b0;
    expect_val("hold_final_y0", K_Y, 0, 31);
    expect_val("hold_release_fast", K_FAST, 0, 0);
    tick();

    // Clamp at the right edge
    override = 1'b0;
    set_x(3, 637);
    expect_val("reload_x3", K_X, 3, 637);
    tick();
    override = 1'b1;
    sel      = 2'd3;
    tick();
    right = 1'b1;
    run_hold("clamp_x3", K_X, 3, 637, 1'b1, 639, 30);
    right = 1'b0;
    expect_val("clamp_final_x3", K_X, 3, 639);
    tick();

    // Clamp at the top edge
    override = 1'b0;
    set_y(0, 7);
    expect_val("reload_y0b", K_Y, 0, 7);
    tick();
    override = 1'b1;
    sel      = 2'd0;
    tick();
    up = 1'b1;
    run_hold("clamp_y0", K_Y, 0, 7, 1'b0, 479, 30);
    up = 1'b0;
    expect_val("clamp_final_y0", K_Y, 0, 0);
    tick();

    // Re-press on sel change mid-REPEAT
    override = 1'b0;
    set_x(0, 300);
    set_x(2, 400);
    expect_val("reload_x0", K_X, 0, 300);
    expect_val("reload_x2", K_X, 2, 400);
    tick();
    override = 1'b1;
    sel      = 2'd0;
    tick();
    left = 1'b1;
    run_hold("repress_x0", K_X, 0, 300, 1'b0, 639, 24);
    sel = 2'd2;
    expect_val("repress_x2", K_X, 2, 399);
    expect_val("repress_x0_hold", K_X, 0, 295);
    expect_val("repress_fast", K_FAST, 0, 0);
    tick();
    for (int k = 25; k <= 32; k++) begin
      expect_val("repress_next_x2", K_X, 2, (k < 32) ? 399 : 398);
      tick();
    end
    tick();

    // Exit mid-REPEAT
    set_x(2, 123);
    override = 1'b0;
    expect_val("exit_x2", K_X, 2, 123);
    expect_val("exit_x0", K_X, 0, 300);
    expect_val("exit_editing", K_EDIT, 0, 0);
    expect_val("exit_fast", K_FAST, 0, 0);
    tick();

    // Reset while a key is held
    override = 1'b1;
    expect_val("recapture_x2", K_X, 2, 123);
    tick();
    expect_val("held_step_x2", K_X, 2, 122);
    tick();
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    expect_val("async_reset_zero", K_ZERO, 0, 1);
    expect_val("async_reset_editing", K_EDIT, 0, 0);
    expect_val("async_reset_fast", K_FAST, 0, 0);
    check_now();
    @(negedge clk);
    reset = 1'b0;
    expect_val("post_reset_capture_x2", K_X, 2, 123);
    expect_val("post_reset_editing", K_EDIT, 0, 1);
    tick();
    expect_val("post_reset_step_x2", K_X, 2, 122);
    tick();
    left     = 1'b0;
    override = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
